fp_div_iter: RTL
================

// Module: fp_div_iter
// PURPOSE
//  Iterative IEEE-754 single-precision divider: result = a / b, the inverse of the FPU multiplier.
//  Radix-2 restoring mantissa division, round-to-nearest-even, full special-case handling.
//  Sits beside the multiplier in the single-precision FPU; valid/ready handshake on both sides.
// PARAMETERS
//  BITS_PER_CYCLE  1  quotient bits per DIV cycle; legal 1 or 2; NDIV = 26/BITS_PER_CYCLE
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   operands valid
//  in_ready   out  1   divider idle, can accept
//  a          in   32  dividend (fp32)
//  b          in   32  divisor (fp32)
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  result     out  32  quotient (fp32)
//  flags      out  5   {invalid, divzero, overflow, underflow, inexact}
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1; out_valid=0; result=0; flags=0; busy=0. Mid-op reset discards the operation.
//  - States: IDLE -> PREP -> DIV (NDIV cycles) -> ROUND -> DONE -> IDLE. Special cases: PREP -> DONE.
//  - Accept in IDLE on in_valid&&in_ready (in_ready=1 only in IDLE); a/b registered at that edge.
//  - Latency from accepting edge to out_valid=1: normal NDIV+3 (29 at default); special 2.
//  - DONE: out_valid=1; result/flags held stable until out_ready=1; that edge -> IDLE (no same-cycle accept).
//  - PREP: sign=a[31]^b[31]; exp = ea - eb + 127 in 10-bit signed; mantissas {1,frac}.
//    If ma < mb, shift ma left 1 and decrement exp, so quotient is in [1,2).
//  - DIV: per bit, rem-mb >= 0 ? (q bit=1, rem-=mb) : q bit=0; rem <<= 1. Result is 26 q bits (1.23 + guard + round).
//  - ROUND: sticky = (rem != 0); RNE on guard/round/sticky. Mantissa carry to 2.0 -> exp+1.
//    inexact = guard|round|sticky.
//  - exp >= 255 after rounding: signed inf, overflow=1, inexact=1.
//  - Specials, checked in PREP in priority order:
//    any NaN -> 0x7FC00000; 0/0 or inf/inf -> 0x7FC00000 with invalid; finite!=0 / 0 -> signed inf with divzero;
//    inf/finite -> signed inf; finite/inf -> signed 0; 0/finite!=0 -> signed 0. No other flags on specials.
//  - Underflow: raised when result is tiny (exp <= 0 before rounding) AND inexact.
//  - flags are valid only while out_valid=1; cleared to 0 in IDLE.
// CONFIGURATION
//  SUBNORMAL_EN defined:
//    - Subnormal inputs are pre-normalised in PREP: leading-one shift, exp adjusted by shift count.
//      PREP stays 1 cycle.
//    - Tiny results are denormalised by right shift (shifted-out bits feed sticky) before RNE: gradual underflow.
//  SUBNORMAL_EN undefined:
//    - Subnormal inputs are treated as signed zero (DAZ).
//    - Tiny results flush to signed zero with underflow=1, inexact=1 (FTZ).
// TESTING
//  - 0x40C00000 / 0x40000000 (6/2) -> 0x40400000, flags 0, out_valid exactly 29 cycles after accept.
//  - 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, flags 5'b00001.
//  - 0x3F800000 / 0x00000000 -> 0x7F800000, divzero, 2-cycle latency.
//    0/0 -> 0x7FC00000, invalid. 0xFF800000 / 0x40000000 -> 0xFF800000.
//  - 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, flags 5'b00101.
//    0x00800000 / 0x40000000: SUBNORMAL_EN -> 0x00400000, flags 0; without -> 0x00000000, flags 5'b00011.
//  - Hold out_ready=0 for 10 cycles -> result/flags stable, in_ready=0.
//    Assert rst at DIV cycle 5 -> next cycle IDLE, out_valid=0; a new op then completes correctly.

Source files
------------

// File: rtl/fp_div_iter_if.sv
// fp_div_iter_if: handshake and data bundle for the iterative fp32 divider.
//   in_valid / in_ready / a / b          : operand request (master -> slave)
//   out_valid / out_ready / result / flags : quotient response (slave -> master)
//   busy                                  : divider is not idle
// flags = {invalid, divzero, overflow, underflow, inexact}
interface fp_div_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  flags;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flags, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flags, busy
    );
endinterface

// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative IEEE-754 single-precision divider, result = a / b.
// Radix-2 restoring mantissa division, round-to-nearest-even, full special-case
// handling. One operation in flight; IDLE -> PREP -> DIV x NDIV -> ROUND -> DONE.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset, discards any operation in flight
//   io   : fp_div_iter_if.slave (operands in, quotient/flags out, busy)
// Parameter BITS_PER_CYCLE (1 or 2): quotient bits retired per DIV cycle.
// Build option SUBNORMAL_EN: when defined, subnormal inputs are pre-normalised
// and tiny results are gradually underflowed; when undefined, subnormal inputs
// read as zero and tiny results flush to signed zero.
module fp_div_iter #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    fp_div_iter_if.slave io
);
    localparam int NDIV = 26 / BITS_PER_CYCLE;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_ROUND, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [25:0]        rem_q, rem_d;
    logic [23:0]        mb_q, mb_d;
    logic [25:0]        quo_q, quo_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [31:0]        result_q, result_d;
    logic [4:0]         flags_q, flags_d;

`ifdef SUBNORMAL_EN
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++)
            if (v[i]) n = 5'(23 - i);
        return n;
    endfunction
`endif

    // Returns {unbiased-with-bias exponent (10b signed), mantissa with leading one at bit 23}.
    function automatic logic [33:0] unpack(input logic [31:0] x);
        logic [23:0]       m;
        logic signed [9:0] e;
`ifdef SUBNORMAL_EN
        logic [4:0]        lz;
        if (x[30:23] == 8'd0) begin
            lz = lzc24({1'b0, x[22:0]});
            m  = {1'b0, x[22:0]} << lz;
            e  = 10'sd1 - signed'({5'd0, lz});
        end else begin
            m = {1'b1, x[22:0]};
            e = signed'({2'b00, x[30:23]});
        end
`else
        m = {1'b1, x[22:0]};
        e = signed'({2'b00, x[30:23]});
`endif
        return {e, m};
    endfunction

    // ---------------- PREP decode ----------------
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
    logic [23:0]       ma_n, mb_n;
    logic signed [9:0] ea_n, eb_n, exp_pre;
    logic [25:0]       rem_pre;

    always_comb begin
        a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
        a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
`ifdef SUBNORMAL_EN
        a_zero = (a_q[30:0] == 31'd0);
        b_zero = (b_q[30:0] == 31'd0);
`else
        a_zero = (a_q[30:23] == 8'd0);
        b_zero = (b_q[30:23] == 8'd0);
`endif
        sgn = a_q[31] ^ b_q[31];
        {ea_n, ma_n} = unpack(a_q);
        {eb_n, mb_n} = unpack(b_q);
        exp_pre = ea_n - eb_n + 10'sd127;
        // Pre-scale the dividend so the quotient lands in [1,2).
        if (ma_n < mb_n) begin
            rem_pre = {1'b0, ma_n, 1'b0};
            exp_pre = exp_pre - 10'sd1;
        end else begin
            rem_pre = {2'b00, ma_n};
        end
    end

    // ---------------- DIV step ----------------
    logic [25:0] rem_nx, quo_nx;

    always_comb begin
        rem_nx = rem_q;
        quo_nx = quo_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (rem_nx >= {2'b00, mb_q}) begin
                rem_nx = (rem_nx - {2'b00, mb_q}) << 1;
                quo_nx = {quo_nx[24:0], 1'b1};
            end else begin
                rem_nx = rem_nx << 1;
                quo_nx = {quo_nx[24:0], 1'b0};
            end
        end
    end

    // ---------------- ROUND ----------------
    // quo_q = 1.xxx (23 frac) | guard | round ; remainder supplies sticky.
    logic              g, r, s, tiny;
    logic [24:0]       m25;
    logic signed [9:0] e_r;
    logic [31:0]       rnd_res;
    logic [4:0]        rnd_flg;
`ifdef SUBNORMAL_EN
    logic signed [9:0] sh_v;
    logic [4:0]        sh;
    logic [51:0]       shv;
    logic              s2;
    logic [23:0]       m24;
`endif

    always_comb begin
        g    = quo_q[1];
        r    = quo_q[0];
        s    = (rem_q != 26'd0);
        tiny = (exp_q <= 10'sd0);
        m25  = {1'b0, quo_q[25:2]} + {24'd0, g & (r | s | quo_q[2])};
        // A carry out of the mantissa means it rounded up to 2.0.
        e_r  = m25[24] ? exp_q + 10'sd1 : exp_q;
        rnd_res = {sign_q, e_r[7:0], m25[24] ? 23'd0 : m25[22:0]};
        rnd_flg = {4'b0000, g | r | s};
`ifdef SUBNORMAL_EN
        sh_v = 10'sd1 - exp_q;
        sh   = 5'd0;
        shv  = '0;
        s2   = 1'b0;
        m24  = '0;
`endif
        if (tiny) begin
`ifdef SUBNORMAL_EN
            // Denormalise: shift so the exponent becomes the minimum; lost bits join sticky.
            sh  = (sh_v > 10'sd27) ? 5'd27 : sh_v[4:0];
            shv = {quo_q, 26'd0} >> sh;
            s2  = s | (shv[25:0] != 26'd0);
            m24 = shv[51:28] + {23'd0, shv[27] & (shv[26] | s2 | shv[28])};
            // Rounding up into the hidden bit yields the smallest normal.
            rnd_res = {sign_q, 7'd0, m24[23], m24[22:0]};
            rnd_flg = {3'b000, shv[27] | shv[26] | s2, shv[27] | shv[26] | s2};
`else
            rnd_res = {sign_q, 31'd0};
            rnd_flg = 5'b00011;
`endif
        end else if (e_r >= 10'sd255) begin
            rnd_res = {sign_q, 8'hFF, 23'd0};
            rnd_flg = 5'b00101;
        end
    end

    // ---------------- FSM / next state ----------------
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        rem_d    = rem_q;
        mb_d     = mb_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            S_IDLE: begin
                if (io.in_valid) begin
                    a_d     = io.a;
                    b_d     = io.b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                sign_d  = sgn;
                state_d = S_DONE;
                if (a_nan || b_nan) begin
                    result_d = 32'h7FC00000;
                    flags_d  = 5'b00000;
                end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                    result_d = 32'h7FC00000;
                    flags_d  = 5'b10000;
                end else if (b_zero && !a_inf) begin
                    result_d = {sgn, 8'hFF, 23'd0};
                    flags_d  = 5'b01000;
                end else if (a_inf) begin
                    result_d = {sgn, 8'hFF, 23'd0};
                    flags_d  = 5'b00000;
                end else if (b_inf || a_zero) begin
                    result_d = {sgn, 31'd0};
                    flags_d  = 5'b00000;
                end else begin
                    exp_d   = exp_pre;
                    rem_d   = rem_pre;
                    mb_d    = mb_n;
                    quo_d   = '0;
                    cnt_d   = 5'(NDIV - 1);
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = S_ROUND;
            end
            S_ROUND: begin
                result_d = rnd_res;
                flags_d  = rnd_flg;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (io.out_ready) begin
                    result_d = '0;
                    flags_d  = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            rem_q    <= '0;
            mb_q     <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            rem_q    <= rem_d;
            mb_q     <= mb_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign io.in_ready  = (state_q == S_IDLE);
    assign io.out_valid = (state_q == S_DONE);
    assign io.busy      = (state_q != S_IDLE);
    assign io.result    = result_q;
    assign io.flags     = flags_q;
endmodule
